// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged sub-block reset release with per-stage init-done watchdog
// Optional feature macro: RESET_SEQ_RETRY_EN (re-hold and retry a timed-out stage up to MAX_RETRIES times)
module reset_sequencer #(
    parameter int NUM_STAGES    = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int STAGE_TIMEOUT = 32,
    parameter int MAX_RETRIES   = 2,
    localparam int SW           = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [NUM_STAGES-1:0] stage_rst_o,
    input  logic [NUM_STAGES-1:0] stage_done_i,
    output logic                  sys_ready_o,
    output logic                  err_o,
    output logic [SW-1:0]         err_stage_o,
    output logic [SW-1:0]         cur_stage_o
);

    localparam int TMAX = (HOLD_CYCLES > STAGE_TIMEOUT) ? HOLD_CYCLES : STAGE_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(STAGE_TIMEOUT - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT,
        ST_READY,
        ST_ERROR
`ifdef RESET_SEQ_RETRY_EN
        , ST_RETRY_HOLD
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic [SW-1:0]         err_stage_q, err_stage_d;
    logic [SW-1:0]         cur_q, cur_d;
    logic                  done_cur;
    logic                  timeout_hit;
    logic                  retry_ok;

`ifdef RESET_SEQ_RETRY_EN
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [RW-1:0] retry_q, retry_d;
    assign retry_ok = (retry_q < RW'(MAX_RETRIES));
`else
    logic unused_max_retries;
    assign unused_max_retries = ^MAX_RETRIES;
    assign retry_ok           = 1'b0;
`endif

    assign done_cur    = stage_done_i[cur_q];
    assign timeout_hit = (STAGE_TIMEOUT > 0) && (timer_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        stage_rst_d = stage_rst_q;
        ready_d     = ready_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;
        cur_d       = cur_q;
`ifdef RESET_SEQ_RETRY_EN
        retry_d     = retry_q;
`endif
        case (state_q)
            ST_HOLD: begin
                if (timer_q == HOLD_LAST) begin
                    stage_rst_d[0] = 1'b0;
                    cur_d          = '0;
                    timer_d        = '0;
                    state_d        = ST_WAIT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT: begin
                // done is checked before the watchdog so an ack on the timeout edge still advances
                if (done_cur) begin
                    timer_d = '0;
`ifdef RESET_SEQ_RETRY_EN
                    retry_d = '0;
`endif
                    if (cur_q == LAST_STAGE) begin
                        ready_d = 1'b1;
                        state_d = ST_READY;
                    end else begin
                        stage_rst_d[cur_q + SW'(1)] = 1'b0;
                        cur_d                       = cur_q + SW'(1);
                    end
                end else if (timeout_hit) begin
                    timer_d = '0;
                    if (retry_ok) begin
                        stage_rst_d[cur_q] = 1'b1;
`ifdef RESET_SEQ_RETRY_EN
                        retry_d = retry_q + RW'(1);
                        state_d = ST_RETRY_HOLD;
`endif
                    end else begin
                        stage_rst_d = '1;
                        err_d       = 1'b1;
                        err_stage_d = cur_q;
                        state_d     = ST_ERROR;
                    end
                end else if (STAGE_TIMEOUT > 0) begin
                    timer_d = timer_q + TW'(1);
                end
            end
`ifdef RESET_SEQ_RETRY_EN
            ST_RETRY_HOLD: begin
                if (timer_q == HOLD_LAST) begin
                    stage_rst_d[cur_q] = 1'b0;
                    timer_d            = '0;
                    state_d            = ST_WAIT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif
            ST_READY: begin
            end
            ST_ERROR: begin
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HOLD;
            timer_q     <= '0;
            stage_rst_q <= '1;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
            cur_q       <= '0;
`ifdef RESET_SEQ_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            stage_rst_q <= stage_rst_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
            cur_q       <= cur_d;
`ifdef RESET_SEQ_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign stage_rst_o = stage_rst_q;
    assign sys_ready_o = ready_q;
    assign err_o       = err_q;
    assign err_stage_o = err_stage_q;
    assign cur_stage_o = cur_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer
// Expected output-change events (edge count since rst release, outputs) are queued up front.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] stage_done = 4'b0000;
    logic [3:0] srst;
    logic       rdy;
    logic       err;
    logic [1:0] estg;
    logic [1:0] cur;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .stage_rst_o  (srst),
        .stage_done_i (stage_done),
        .sys_ready_o  (rdy),
        .err_o        (err),
        .err_stage_o  (estg),
        .cur_stage_o  (cur)
    );

    typedef struct {
        int         t;
        logic [9:0] v;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  t = 0;

    // edges sampling rst=0 since the last edge sampling rst=1
    always @(posedge clk) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    function automatic void expect_ev(input int tt, input logic [3:0] s, input logic r,
                                      input logic e, input logic [1:0] es, input logic [1:0] c);
        ev_t ev;
        ev.t = tt;
        ev.v = {s, r, e, es, c};
        exp_q.push_back(ev);
    endfunction

    logic [9:0] prev = 'x;

    always @(negedge clk) begin
        logic [9:0] snap;
        ev_t        ev;
        snap = {srst, rdy, err, estg, cur};
        if (snap !== prev) begin
            prev <= snap;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event t=%0d got=%b required=none", t, snap);
            end else begin
                ev = exp_q.pop_front();
                if (ev.t != t) begin
                    errors++;
                    $display("FAIL event_time got_t=%0d required_t=%0d (value %b)", t, ev.t, ev.v);
                end
                checks++;
                if (snap !== ev.v) begin
                    errors++;
                    $display("FAIL event_value t=%0d got=%b required=%b (srst,rdy,err,estg,cur)",
                             t, snap, ev.v);
                end
            end
        end
    end

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to(input int target);
        int g = 0;
        while (t < target && g < 2000) begin
            @(negedge clk);
            g++;
        end
    endtask

    // done[i] rises 3 cycles after stage i's release, so it is sampled on the 4th edge
    task automatic drive_nominal(input int stop_t);
        int g = 0;
        while (t < stop_t && g < 2000) begin
            for (int i = 0; i < 4; i++)
                if (t >= 8 + 4 * i + 3) stage_done[i] = 1'b1;
            @(negedge clk);
            g++;
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_events got=%0d pending required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic expect_nominal();
        expect_ev(0,  4'b1111, 0, 0, 2'd0, 2'd0);
        expect_ev(8,  4'b1110, 0, 0, 2'd0, 2'd0);
        expect_ev(12, 4'b1100, 0, 0, 2'd0, 2'd1);
        expect_ev(16, 4'b1000, 0, 0, 2'd0, 2'd2);
        expect_ev(20, 4'b0000, 0, 0, 2'd0, 2'd3);
        expect_ev(24, 4'b0000, 1, 0, 2'd0, 2'd3);
    endtask

`ifdef RESET_SEQ_RETRY_EN
    localparam int T_ERR = 122;
`else
    localparam int T_ERR = 42;
`endif

    initial begin
        // nominal sequence, later done drop ignored in READY
        expect_nominal();
        stage_done = 4'b0000;
        apply_reset(8);
        drive_nominal(30);
        stage_done = 4'b0000;
        run_to(36);
        check_drained("nominal");

        // all done high from reset: one release per edge, ready at 12
        expect_ev(0,  4'b1111, 0, 0, 2'd0, 2'd0);
        expect_ev(8,  4'b1110, 0, 0, 2'd0, 2'd0);
        expect_ev(9,  4'b1100, 0, 0, 2'd0, 2'd1);
        expect_ev(10, 4'b1000, 0, 0, 2'd0, 2'd2);
        expect_ev(11, 4'b0000, 0, 0, 2'd0, 2'd3);
        expect_ev(12, 4'b0000, 1, 0, 2'd0, 2'd3);
        stage_done = 4'b1111;
        apply_reset(8);
        run_to(16);
        check_drained("immediate");

        // stage 2 never acks: watchdog fires 32 edges after its release
        expect_ev(0,  4'b1111, 0, 0, 2'd0, 2'd0);
        expect_ev(8,  4'b1110, 0, 0, 2'd0, 2'd0);
        expect_ev(9,  4'b1100, 0, 0, 2'd0, 2'd1);
        expect_ev(10, 4'b1000, 0, 0, 2'd0, 2'd2);
`ifdef RESET_SEQ_RETRY_EN
        expect_ev(42, 4'b1100, 0, 0, 2'd0, 2'd2);
        expect_ev(50, 4'b1000, 0, 0, 2'd0, 2'd2);
        expect_ev(82, 4'b1100, 0, 0, 2'd0, 2'd2);
        expect_ev(90, 4'b1000, 0, 0, 2'd0, 2'd2);
`endif
        expect_ev(T_ERR, 4'b1111, 0, 1, 2'd2, 2'd2);
        stage_done = 4'b0011;
        apply_reset(8);
        run_to(T_ERR + 3);
        stage_done = 4'b1111;
        run_to(T_ERR + 10);
        check_drained("timeout");

        // stage 1 ack arrives exactly on the timeout edge
        expect_ev(0,  4'b1111, 0, 0, 2'd0, 2'd0);
        expect_ev(8,  4'b1110, 0, 0, 2'd0, 2'd0);
        expect_ev(9,  4'b1100, 0, 0, 2'd0, 2'd1);
        expect_ev(41, 4'b1000, 0, 0, 2'd0, 2'd2);
        expect_ev(42, 4'b0000, 0, 0, 2'd0, 2'd3);
        expect_ev(43, 4'b0000, 1, 0, 2'd0, 2'd3);
        stage_done = 4'b0001;
        apply_reset(8);
        run_to(40);
        stage_done = 4'b1111;
        run_to(48);
        check_drained("done_on_timeout_edge");

        // one-cycle reset while waiting on stage 2, then full sequence again
        expect_ev(0,  4'b1111, 0, 0, 2'd0, 2'd0);
        expect_ev(8,  4'b1110, 0, 0, 2'd0, 2'd0);
        expect_ev(12, 4'b1100, 0, 0, 2'd0, 2'd1);
        expect_ev(16, 4'b1000, 0, 0, 2'd0, 2'd2);
        expect_nominal();
        stage_done = 4'b0000;
        apply_reset(8);
        drive_nominal(17);
        stage_done = 4'b0000;
        apply_reset(1);
        drive_nominal(30);
        check_drained("mid_reset");

`ifdef RESET_SEQ_RETRY_EN
        // stage 0 retried once, then acks 2 edges after re-release
        expect_ev(0,  4'b1111, 0, 0, 2'd0, 2'd0);
        expect_ev(8,  4'b1110, 0, 0, 2'd0, 2'd0);
        expect_ev(40, 4'b1111, 0, 0, 2'd0, 2'd0);
        expect_ev(48, 4'b1110, 0, 0, 2'd0, 2'd0);
        expect_ev(50, 4'b1100, 0, 0, 2'd0, 2'd1);
        expect_ev(51, 4'b1000, 0, 0, 2'd0, 2'd2);
        expect_ev(52, 4'b0000, 0, 0, 2'd0, 2'd3);
        expect_ev(53, 4'b0000, 1, 0, 2'd0, 2'd3);
        stage_done = 4'b0000;
        apply_reset(8);
        run_to(49);
        stage_done = 4'b1111;
        run_to(58);
        check_drained("retry");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=time_limit required=finish");
        $fatal(1);
    end

endmodule
